// File: rtl/axi_lite_slave_regfile_pkg.sv
// Shared types and constants for the AXI4-Lite slave register file.
package axi_lite_slave_regfile_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      WR_RST    = 3'd0,
      WR_IDLE   = 3'd1,
      WR_WAIT_W = 3'd2,
      WR_WAIT_A = 3'd3,
      WR_RESP   = 3'd4
   } wr_state_e;

   typedef enum logic [2:0] {
      RD_RST  = 3'd0,
      RD_IDLE = 3'd1,
      RD_DATA = 3'd2
   } rd_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
   } wbeat_t;

   function automatic logic [1:0] resp_of(input logic ok);
      return ok ? RESP_OKAY : RESP_SLVERR;
   endfunction

endpackage

// File: rtl/axi_lite_reg_array.sv
// NUM x DW register storage with a byte-strobed write port, combinational read mux
// and a flattened export of every register.
module axi_lite_reg_array #(
   parameter int unsigned   NUM         = 16,
   parameter int unsigned   DW          = 32,
   parameter int unsigned   IW          = 4,
   parameter logic [DW-1:0] RESET_VALUE = '0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic [IW-1:0]     i_wr_idx,
   input  logic [DW-1:0]     i_wr_data,
   input  logic [DW/8-1:0]   i_wr_strb,
   input  logic [IW-1:0]     i_rd_idx,
   output logic [DW-1:0]     o_rd_data_c,
   output logic [NUM*DW-1:0] o_regs
);

   localparam int unsigned SW = DW / 8;

   logic [DW-1:0] w_regs [NUM];

   for (genvar g = 0; g < NUM; g++) begin : g_reg
      logic [DW-1:0] r_q;

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_q <= RESET_VALUE;
         end else if (i_wr_en && (i_wr_idx == IW'(g))) begin
            for (int unsigned b = 0; b < SW; b++) begin
               if (i_wr_strb[b]) r_q[8*b +: 8] <= i_wr_data[8*b +: 8];
            end
         end
      end

      assign w_regs[g]              = r_q;
      assign o_regs[g*DW +: DW]     = r_q;
   end

   assign o_rd_data_c = w_regs[i_rd_idx];

endmodule

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave register file: independent write/read FSMs in front of a
// byte-strobed register array that is exported flat to user logic.
module axi_lite_slave_regfile
   import axi_lite_slave_regfile_pkg::*;
#(
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_NUM_REGS         = 16,
   parameter logic [31:0] C_RESET_VALUE      = 32'h0
) (
   input  logic                                     S_AXI_ACLK,
   input  logic                                     S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
   input  logic [2:0]                               S_AXI_AWPROT,
   input  logic                                     S_AXI_AWVALID,
   output logic                                     S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
   input  logic                                     S_AXI_WVALID,
   output logic                                     S_AXI_WREADY,
   output logic [1:0]                               S_AXI_BRESP,
   output logic                                     S_AXI_BVALID,
   input  logic                                     S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
   input  logic [2:0]                               S_AXI_ARPROT,
   input  logic                                     S_AXI_ARVALID,
   output logic                                     S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
   output logic [1:0]                               S_AXI_RRESP,
   output logic                                     S_AXI_RVALID,
   input  logic                                     S_AXI_RREADY,
   output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regOut,
   output logic [C_NUM_REGS-1:0]                    regWrPulse
);

   localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
   localparam int unsigned IW = $clog2(C_NUM_REGS);

   function automatic logic addr_in_range(input logic [AW-1:0] a);
      return a[AW-1:IW+2] == '0;
   endfunction

   wr_state_e            r_wr_state, w_wr_next;
   logic                 r_awready, r_wready, r_bvalid;
   logic [1:0]           r_bresp;
   logic [C_NUM_REGS-1:0] r_wr_pulse;
   logic [AW-1:0]        r_aw_addr;
   wbeat_t               r_w;
   logic                 w_commit, w_lat_aw, w_lat_w, w_wr_en;
   logic [AW-1:0]        w_cmt_addr;
   wbeat_t               w_cmt_w;

   rd_state_e            r_rd_state, w_rd_next;
   logic                 r_arready, r_rvalid;
   logic [DW-1:0]        r_rdata;
   logic [1:0]           r_rresp;
   logic                 w_ar_hs, w_rd_ok;
   logic [DW-1:0]        w_rd_data_c;

   // Write FSM: AW and W may arrive in either order; commit on the later handshake.
   always_comb begin
      w_wr_next     = r_wr_state;
      w_commit      = 1'b0;
      w_lat_aw      = 1'b0;
      w_lat_w       = 1'b0;
      w_cmt_addr    = S_AXI_AWADDR;
      w_cmt_w.data  = S_AXI_WDATA;
      w_cmt_w.strb  = S_AXI_WSTRB;
      case (r_wr_state)
         WR_RST:  w_wr_next = WR_IDLE;
         WR_IDLE: begin
            if (S_AXI_AWVALID && S_AXI_WVALID) begin
               w_commit  = 1'b1;
               w_wr_next = WR_RESP;
            end else if (S_AXI_AWVALID) begin
               w_lat_aw  = 1'b1;
               w_wr_next = WR_WAIT_W;
            end else if (S_AXI_WVALID) begin
               w_lat_w   = 1'b1;
               w_wr_next = WR_WAIT_A;
            end
         end
         WR_WAIT_W: begin
            w_cmt_addr = r_aw_addr;
            if (S_AXI_WVALID) begin
               w_commit  = 1'b1;
               w_wr_next = WR_RESP;
            end
         end
         WR_WAIT_A: begin
            w_cmt_w = r_w;
            if (S_AXI_AWVALID) begin
               w_commit  = 1'b1;
               w_wr_next = WR_RESP;
            end
         end
         WR_RESP: if (S_AXI_BREADY) w_wr_next = WR_IDLE;
         default: w_wr_next = WR_RST;
      endcase
   end

   assign w_wr_en = w_commit && addr_in_range(w_cmt_addr);

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) r_wr_state <= WR_RST;
      else              r_wr_state <= w_wr_next;
   end

   // Handshake outputs are registered from the next state so they track it exactly.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_awready  <= 1'b0;
         r_wready   <= 1'b0;
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_wr_pulse <= '0;
         r_aw_addr  <= '0;
         r_w        <= '0;
      end else begin
         r_awready  <= (w_wr_next == WR_IDLE) || (w_wr_next == WR_WAIT_A);
         r_wready   <= (w_wr_next == WR_IDLE) || (w_wr_next == WR_WAIT_W);
         r_bvalid   <= (w_wr_next == WR_RESP);
         r_wr_pulse <= '0;
         if (w_wr_en)  r_wr_pulse[w_cmt_addr[IW+1:2]] <= 1'b1;
         if (w_commit) r_bresp <= resp_of(w_wr_en);
         if (w_lat_aw) r_aw_addr <= S_AXI_AWADDR;
         if (w_lat_w) begin
            r_w.data <= S_AXI_WDATA;
            r_w.strb <= S_AXI_WSTRB;
         end
      end
   end

   // Read FSM: capture on AR handshake, hold until RREADY.
   always_comb begin
      w_rd_next = r_rd_state;
      w_ar_hs   = 1'b0;
      case (r_rd_state)
         RD_RST:  w_rd_next = RD_IDLE;
         RD_IDLE: begin
            if (S_AXI_ARVALID) begin
               w_ar_hs   = 1'b1;
               w_rd_next = RD_DATA;
            end
         end
         RD_DATA: if (S_AXI_RREADY) w_rd_next = RD_IDLE;
         default: w_rd_next = RD_RST;
      endcase
   end

   assign w_rd_ok = addr_in_range(S_AXI_ARADDR);

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) r_rd_state <= RD_RST;
      else              r_rd_state <= w_rd_next;
   end

   // Array reads see the pre-write value when a commit lands on the same edge.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
      end else begin
         r_arready <= (w_rd_next == RD_IDLE);
         r_rvalid  <= (w_rd_next == RD_DATA);
         if (w_ar_hs) begin
            r_rdata <= w_rd_ok ? w_rd_data_c : '0;
            r_rresp <= resp_of(w_rd_ok);
         end
      end
   end

   axi_lite_reg_array #(
      .NUM         (C_NUM_REGS),
      .DW          (DW),
      .IW          (IW),
      .RESET_VALUE (C_RESET_VALUE)
   ) u_regs (
      .i_clk       (S_AXI_ACLK),
      .i_rst       (S_AXI_ARESET),
      .i_wr_en     (w_wr_en),
      .i_wr_idx    (w_cmt_addr[IW+1:2]),
      .i_wr_data   (w_cmt_w.data),
      .i_wr_strb   (w_cmt_w.strb),
      .i_rd_idx    (S_AXI_ARADDR[IW+1:2]),
      .o_rd_data_c (w_rd_data_c),
      .o_regs      (regOut)
   );

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;
   assign regWrPulse    = r_wr_pulse;

   logic w_unused;
   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], w_cmt_addr[1:0]};

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Directed plus randomized bench for axi_lite_slave_regfile against a register-array model.
module tb_axi_lite_slave_regfile;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  awaddr, wdata, araddr;
   logic [2:0]   awprot, arprot;
   logic [3:0]   wstrb;
   logic         awvalid, wvalid, bready, arvalid, rready;
   logic         awready, wready, bvalid, arready, rvalid;
   logic [1:0]   bresp, rresp;
   logic [31:0]  rdata;
   logic [511:0] reg_out;
   logic [15:0]  reg_pulse;

   logic [31:0]  model [16];
   int           n_checks = 0;
   int           n_fail   = 0;

   always #5 clk = ~clk;

   axi_lite_slave_regfile dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESET  (rst),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .regOut        (reg_out),
      .regWrPulse    (reg_pulse)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 16; i++) check(tag, 64'(reg_out[i*32 +: 32]), 64'(model[i]));
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned r = $urandom_range(0, 9);
      if (r == 0) return $urandom;
      if (r == 1) return 32'h40 + 32'($urandom_range(0, 255));
      return 32'($urandom_range(0, 63));
   endfunction

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
      bit          aw_done = 0, w_done = 0, hs_aw, hs_w;
      int          c = 0;
      bit          ok = (addr < 32'd64);
      int          idx = int'((addr / 4) % 16);
      logic [31:0] mask = '0;
      logic [15:0] exp_pulse = '0;
      while (!(aw_done && w_done) && c < 40) begin
         @(negedge clk);
         check("bvalid_early", 64'(bvalid), 64'd0);
         awvalid = !aw_done && c >= aw_dly;
         awaddr  = addr;
         wvalid  = !w_done && c >= w_dly;
         wdata   = data;
         wstrb   = strb;
         hs_aw   = awvalid && awready;
         hs_w    = wvalid && wready;
         @(posedge clk);
         aw_done |= hs_aw;
         w_done  |= hs_w;
         c++;
      end
      check("wr_handshake", 64'(aw_done && w_done), 64'd1);
      for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
      if (ok) begin
         model[idx]     = (model[idx] & ~mask) | (data & mask);
         exp_pulse[idx] = 1'b1;
      end
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      for (int k = 0; k <= b_dly; k++) begin
         if (k > 0) @(negedge clk);
         check("bvalid", 64'(bvalid), 64'd1);
         check("bresp", 64'(bresp), ok ? 64'd0 : 64'd2);
         check("awready_in_resp", 64'(awready), 64'd0);
         if (k == 0) begin
            check("wr_pulse", 64'(reg_pulse), 64'(exp_pulse));
            if (ok) check("reg_after_write", 64'(reg_out[idx*32 +: 32]), 64'(model[idx]));
            else    check_regs("reg_after_slverr");
         end else if (k == 1) begin
            check("wr_pulse_clear", 64'(reg_pulse), 64'd0);
         end
         bready = (k == b_dly);
      end
      @(posedge clk);
      @(negedge clk);
      bready = 1'b0;
      check("bvalid_drop", 64'(bvalid), 64'd0);
      check("wr_pulse_idle", 64'(reg_pulse), 64'd0);
      check("readies_idle", 64'({awready, wready}), 64'd3);
   endtask

   task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
      bit          done = 0, hs;
      int          c = 0;
      bit          ok = (addr < 32'd64);
      logic [31:0] exp_data = ok ? model[int'((addr / 4) % 16)] : 32'h0;
      while (!done && c < 40) begin
         @(negedge clk);
         check("rvalid_early", 64'(rvalid), 64'd0);
         arvalid = c >= ar_dly;
         araddr  = addr;
         arprot  = 3'($urandom);
         hs      = arvalid && arready;
         @(posedge clk);
         done = hs;
         c++;
      end
      check("rd_handshake", 64'(done), 64'd1);
      @(negedge clk);
      arvalid = 1'b0;
      for (int k = 0; k <= r_dly; k++) begin
         if (k > 0) @(negedge clk);
         check("rvalid", 64'(rvalid), 64'd1);
         check("rdata", 64'(rdata), 64'(exp_data));
         check("rresp", 64'(rresp), ok ? 64'd0 : 64'd2);
         rready = (k == r_dly);
      end
      @(posedge clk);
      @(negedge clk);
      rready = 1'b0;
      check("rvalid_drop", 64'(rvalid), 64'd0);
      check("arready_idle", 64'(arready), 64'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] old_val;
      rst = 1'b1;
      {awvalid, wvalid, bready, arvalid, rready} = '0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      awprot = 3'b010; arprot = 3'b000;
      for (int i = 0; i < 16; i++) model[i] = 32'h0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_readies", 64'({awready, wready, arready}), 64'd0);
      check("rst_valids", 64'({bvalid, rvalid}), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      check("rst_pulse", 64'(reg_pulse), 64'd0);
      check_regs("rst_regs");
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_readies", 64'({awready, wready, arready}), 64'd7);

      // Directed scenarios
      do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      do_write(32'h04, 32'h11223344, 4'hF, 0, 0, 1);
      do_write(32'h04, 32'h000000AA, 4'h1, 0, 3, 0);
      check("reg1_merge", 64'(reg_out[1*32 +: 32]), 64'h112233AA);
      do_write(32'h40, 32'hCAFEF00D, 4'hF, 2, 0, 2);
      do_read(32'h08, 0, 5);
      do_write(32'h14, 32'h12345678, 4'h0, 1, 0, 0);

      // Same-edge AR and write commit to one register
      old_val = model[3];
      @(negedge clk);
      awvalid = 1'b1; awaddr = 32'h0C; wvalid = 1'b1; wdata = 32'h5; wstrb = 4'hF;
      arvalid = 1'b1; araddr = 32'h0C;
      check("same_edge_ready", 64'({awready, wready, arready}), 64'd7);
      @(posedge clk);
      @(negedge clk);
      {awvalid, wvalid, arvalid} = '0;
      model[3] = 32'h5;
      check("same_edge_rdata_old", 64'(rdata), 64'(old_val));
      check("same_edge_valids", 64'({bvalid, rvalid}), 64'd3);
      bready = 1'b1; rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bready = 1'b0; rready = 1'b0;
      check("same_edge_done", 64'({bvalid, rvalid}), 64'd0);
      do_read(32'h0C, 1, 0);

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         do_write(rand_addr(), $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
         do_read(rand_addr(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
         if (n % 15 == 14) check_regs("rand_regs");
      end

      // Reset while a write response and read data are both pending
      @(negedge clk);
      awvalid = 1'b1; awaddr = 32'h10; wvalid = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
      arvalid = 1'b1; araddr = 32'h08;
      @(posedge clk);
      @(negedge clk);
      {awvalid, wvalid, arvalid} = '0;
      check("pre_rst_valids", 64'({bvalid, rvalid}), 64'd3);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
      check("mid_rst_valids", 64'({bvalid, rvalid}), 64'd0);
      check("mid_rst_readies", 64'({awready, wready, arready}), 64'd0);
      check_regs("mid_rst_regs");
      rst = 1'b0;
      check("first_post_rst_readies", 64'({awready, wready, arready}), 64'd0);
      @(negedge clk);
      check("second_post_rst_readies", 64'({awready, wready, arready}), 64'd7);
      check("post_rst_valids", 64'({bvalid, rvalid}), 64'd0);
      do_read(32'h10, 0, 0);
      do_write(32'h3C, 32'h0BADF00D, 4'hC, 0, 1, 0);
      do_read(32'h3C, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
